// File: rtl/addsub_seq_pkg.sv
// Shared definitions for the add/sub sequencer: FSM encoding, saturation limits, default settle time.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package addsub_seq_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      SETTLE = 2'd1,
      RESP   = 2'd2
   } seq_state_e;

   localparam logic [31:0] SAT_POS = 32'h7FFFFFFF;
   localparam logic [31:0] SAT_NEG = 32'h80000000;

   // Eight 10 ns cycles comfortably cover the ~66 gate delays of the full carry ripple.
   localparam int DEF_SETTLE_CYCLES = 8;

endpackage

// File: rtl/addsub32.sv
// 32-bit ripple-carry adder/subtractor datapath (A+B or A-B), unit-gate-delay structure.
// Latency: purely combinational; outputs settle after the worst-case carry ripple.
// Backpressure: none; caller must hold inputs stable until the ripple has settled.
module addsub32 (
   input  logic [31:0] a_i,
   input  logic [31:0] b_i,
   input  logic        sub_i,
   output logic [31:0] ans_o,
   output logic        cout_o,
   output logic        v_o
);

   logic [32:0] c;
   logic [31:0] bx;

   // Subtraction is A + ~B + 1: invert B and inject the +1 as carry-in.
   assign bx   = b_i ^ {32{sub_i}};
   assign c[0] = sub_i;

   genvar i;
   generate
      for (i = 0; i < 32; i++) begin : g_bit
         assign ans_o[i] = a_i[i] ^ bx[i] ^ c[i];
         assign c[i+1]   = (a_i[i] & bx[i]) | (c[i] & (a_i[i] ^ bx[i]));
      end
   endgenerate

   assign cout_o = c[32];
   // Signed overflow: carry into the sign bit differs from carry out of it.
   assign v_o    = c[31] ^ c[32];

endmodule

// File: rtl/addsub_rr_arb2.sv
// Two-way round-robin grant: a lone requester wins, ties go to the side rr_ptr points at.
// Latency: combinational.
// Backpressure: none; the caller decides when the grant is consumed and moves the pointer.
module addsub_rr_arb2 (
   input  logic valid0_i,
   input  logic valid1_i,
   input  logic rr_ptr_i,
   output logic grant_o,
   output logic any_grant_o
);

   // Pick the winner from the valid pattern; the pointer only matters on a tie.
   always_comb begin
      grant_o     = 1'b0;
      any_grant_o = valid0_i | valid1_i;
      if (valid0_i && valid1_i) begin
         grant_o = rr_ptr_i;
      end else if (valid1_i) begin
         grant_o = 1'b1;
      end
   end

endmodule

// File: rtl/addsub_sequencer.sv
// Shares one addsub32 between two requesters: round-robin accept, hold operands SETTLE_CYCLES, capture, respond.
// Latency: rsp_valid rises SETTLE_CYCLES cycles after the accept edge; back-to-back issue every SETTLE_CYCLES+2.
// Backpressure: result held in RESP until rsp_ready; no new grant until the response is taken. Build option ADDSUB_SAT_EN saturates ans on overflow.
module addsub_sequencer
   import addsub_seq_pkg::*;
#(
   parameter int SETTLE_CYCLES = DEF_SETTLE_CYCLES,
   parameter int CNT_W         = 8
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        req0_valid,
   output logic        req0_ready,
   input  logic [31:0] req0_a,
   input  logic [31:0] req0_b,
   input  logic        req0_sub,
   input  logic        req1_valid,
   output logic        req1_ready,
   input  logic [31:0] req1_a,
   input  logic [31:0] req1_b,
   input  logic        req1_sub,
   output logic        rsp_valid,
   input  logic        rsp_ready,
   output logic        rsp_id,
   output logic [31:0] rsp_ans,
   output logic        rsp_cout,
   output logic        rsp_v
);

   seq_state_e        state_q, state_d;
   logic              rr_ptr_q, rr_ptr_d;
   logic [31:0]       op_a_q, op_a_d;
   logic [31:0]       op_b_q, op_b_d;
   logic              op_sub_q, op_sub_d;
   logic              id_q, id_d;
   logic [CNT_W-1:0]  cnt_q, cnt_d;
   logic              rsp_valid_q, rsp_valid_d;
   logic              rsp_id_q, rsp_id_d;
   logic [31:0]       rsp_ans_q, rsp_ans_d;
   logic              rsp_cout_q, rsp_cout_d;
   logic              rsp_v_q, rsp_v_d;

   logic              grant;
   logic              any_grant;
   logic [31:0]       dp_ans;
   logic              dp_cout;
   logic              dp_v;
   logic [31:0]       cap_ans;

   addsub_rr_arb2 u_arb (
      .valid0_i    (req0_valid),
      .valid1_i    (req1_valid),
      .rr_ptr_i    (rr_ptr_q),
      .grant_o     (grant),
      .any_grant_o (any_grant)
   );

   // Datapath sees only the registered operands, so its inputs are frozen for the whole settle window.
   addsub32 u_dp (
      .a_i    (op_a_q),
      .b_i    (op_b_q),
      .sub_i  (op_sub_q),
      .ans_o  (dp_ans),
      .cout_o (dp_cout),
      .v_o    (dp_v)
   );

`ifdef ADDSUB_SAT_EN
   // A wrapped negative ans means the true result overflowed upward, and vice versa.
   assign cap_ans = dp_v ? (dp_ans[31] ? SAT_POS : SAT_NEG) : dp_ans;
`else
   assign cap_ans = dp_ans;
`endif

   // Ready only in IDLE toward the arbiter's winner; forced low while reset is applied.
   assign req0_ready = ~rst & (state_q == IDLE) & any_grant & ~grant;
   assign req1_ready = ~rst & (state_q == IDLE) & any_grant &  grant;

   assign rsp_valid = rsp_valid_q;
   assign rsp_id    = rsp_id_q;
   assign rsp_ans   = rsp_ans_q;
   assign rsp_cout  = rsp_cout_q;
   assign rsp_v     = rsp_v_q;

   // Next-state: accept in IDLE, count down in SETTLE, capture at zero, wait for the consumer in RESP.
   always_comb begin
      state_d     = state_q;
      rr_ptr_d    = rr_ptr_q;
      op_a_d      = op_a_q;
      op_b_d      = op_b_q;
      op_sub_d    = op_sub_q;
      id_d        = id_q;
      cnt_d       = cnt_q;
      rsp_valid_d = rsp_valid_q;
      rsp_id_d    = rsp_id_q;
      rsp_ans_d   = rsp_ans_q;
      rsp_cout_d  = rsp_cout_q;
      rsp_v_d     = rsp_v_q;
      case (state_q)
         IDLE: begin
            if (any_grant) begin
               op_a_d   = grant ? req1_a   : req0_a;
               op_b_d   = grant ? req1_b   : req0_b;
               op_sub_d = grant ? req1_sub : req0_sub;
               id_d     = grant;
               rr_ptr_d = ~grant;
               cnt_d    = CNT_W'(SETTLE_CYCLES - 1);
               state_d  = SETTLE;
            end
         end
         SETTLE: begin
            if (cnt_q == '0) begin
               rsp_valid_d = 1'b1;
               rsp_id_d    = id_q;
               rsp_ans_d   = cap_ans;
               rsp_cout_d  = dp_cout;
               rsp_v_d     = dp_v;
               state_d     = RESP;
            end else begin
               cnt_d = cnt_q - CNT_W'(1);
            end
         end
         RESP: begin
            if (rsp_valid_q && rsp_ready) begin
               rsp_valid_d = 1'b0;
               state_d     = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   // State and datapath registers; reset discards any in-flight operation.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q     <= IDLE;
         rr_ptr_q    <= 1'b0;
         op_a_q      <= '0;
         op_b_q      <= '0;
         op_sub_q    <= 1'b0;
         id_q        <= 1'b0;
         cnt_q       <= '0;
         rsp_valid_q <= 1'b0;
         rsp_id_q    <= 1'b0;
         rsp_ans_q   <= '0;
         rsp_cout_q  <= 1'b0;
         rsp_v_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         rr_ptr_q    <= rr_ptr_d;
         op_a_q      <= op_a_d;
         op_b_q      <= op_b_d;
         op_sub_q    <= op_sub_d;
         id_q        <= id_d;
         cnt_q       <= cnt_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_id_q    <= rsp_id_d;
         rsp_ans_q   <= rsp_ans_d;
         rsp_cout_q  <= rsp_cout_d;
         rsp_v_q     <= rsp_v_d;
      end
   end

endmodule

// File: tb/tb_addsub_sequencer.sv
// Self-checking bench for addsub_sequencer: directed cases plus random traffic against an arithmetic model.
// Latency: expects rsp_valid exactly S cycles after the accept edge.
// Backpressure: exercises long rsp_ready stalls and reset during the settle window.
module tb_addsub_sequencer;
   import addsub_seq_pkg::*;

   localparam int S = 8;

   logic        clk;
   logic        rst;
   logic        req0_valid, req0_ready, req0_sub;
   logic [31:0] req0_a, req0_b;
   logic        req1_valid, req1_ready, req1_sub;
   logic [31:0] req1_a, req1_b;
   logic        rsp_valid, rsp_ready, rsp_id, rsp_cout, rsp_v;
   logic [31:0] rsp_ans;

   int   vecs = 0;
   int   errs = 0;
   logic last_winner = 1'b1;

   addsub_sequencer #(.SETTLE_CYCLES(S), .CNT_W(8)) dut (
      .clk        (clk),
      .rst        (rst),
      .req0_valid (req0_valid),
      .req0_ready (req0_ready),
      .req0_a     (req0_a),
      .req0_b     (req0_b),
      .req0_sub   (req0_sub),
      .req1_valid (req1_valid),
      .req1_ready (req1_ready),
      .req1_a     (req1_a),
      .req1_b     (req1_b),
      .req1_sub   (req1_sub),
      .rsp_valid  (rsp_valid),
      .rsp_ready  (rsp_ready),
      .rsp_id     (rsp_id),
      .rsp_ans    (rsp_ans),
      .rsp_cout   (rsp_cout),
      .rsp_v      (rsp_v)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation did not finish, observed timeout expected completion");
      $fatal(1, "watchdog expired");
   end

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vecs++;
      assert (obs === exp) else begin
         errs++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   // Two's complement arithmetic on 33-bit integers; overflow from operand/result signs.
   function automatic void ref_calc(input logic [31:0] a, input logic [31:0] b, input logic s,
                                    output logic [31:0] ans, output logic c, output logic v);
      logic [32:0] sum;
      if (s) sum = {1'b0, a} + {1'b0, ~b} + 33'd1;
      else   sum = {1'b0, a} + {1'b0, b};
      ans = sum[31:0];
      c   = sum[32];
      if (s) v = (a[31] != b[31]) && (ans[31] != a[31]);
      else   v = (a[31] == b[31]) && (ans[31] != a[31]);
`ifdef ADDSUB_SAT_EN
      if (v) ans = a[31] ? SAT_NEG : SAT_POS;
`endif
   endfunction

   task automatic check_reset_outputs(input string tag);
      chk({tag, "_rsp_valid"}, rsp_valid, 1'b0);
      chk({tag, "_rsp_id"}, rsp_id, 1'b0);
      chk({tag, "_rsp_ans"}, rsp_ans, 32'h0);
      chk({tag, "_rsp_cout"}, rsp_cout, 1'b0);
      chk({tag, "_rsp_v"}, rsp_v, 1'b0);
      chk({tag, "_readies"}, {req0_ready, req1_ready}, 2'b00);
   endtask

   // One full transaction: present requests, observe grant, time the response, stall, then take it.
   task automatic run_op(input logic v0, input logic v1,
                         input logic [31:0] a0, input logic [31:0] b0, input logic s0,
                         input logic [31:0] a1, input logic [31:0] b1, input logic s1,
                         input int hold);
      logic        win;
      logic [31:0] ea;
      logic        ec, ev;
      bit          got;
      int          lat;
      req0_valid = v0; req0_a = a0; req0_b = b0; req0_sub = s0;
      req1_valid = v1; req1_a = a1; req1_b = b1; req1_sub = s1;
      if (v0 && !v1)      win = 1'b0;
      else if (v1 && !v0) win = 1'b1;
      else                win = ~last_winner;
      got = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (req0_ready || req1_ready) begin
            got = 1;
            break;
         end
      end
      chk("grant_seen", got, 1'b1);
      if (!got) return;
      chk("ready0", req0_ready, !win);
      chk("ready1", req1_ready, win);
      if (win) ref_calc(a1, b1, s1, ea, ec, ev);
      else     ref_calc(a0, b0, s0, ea, ec, ev);
      last_winner = win;
      @(posedge clk);
      #1;
      req0_a = $urandom; req0_b = $urandom; req0_sub = 1'($urandom);
      req1_a = $urandom; req1_b = $urandom; req1_sub = 1'($urandom);
      lat = -1;
      for (int k = 0; k <= S + 4; k++) begin
         @(negedge clk);
         if (rsp_valid) begin
            lat = k;
            break;
         end
         chk("ready_low_settle", {req0_ready, req1_ready}, 2'b00);
      end
      chk("latency", 64'(lat), 64'(S));
      if (lat < 0) return;
      chk("rsp_ans", rsp_ans, ea);
      chk("rsp_cout", rsp_cout, ec);
      chk("rsp_v", rsp_v, ev);
      chk("rsp_id", rsp_id, win);
      for (int h = 0; h < hold; h++) begin
         req0_valid = 1'b1; req1_valid = 1'b1;
         req0_a = $urandom; req0_b = $urandom; req0_sub = 1'($urandom);
         req1_a = $urandom; req1_b = $urandom; req1_sub = 1'($urandom);
         @(negedge clk);
         chk("hold_valid", rsp_valid, 1'b1);
         chk("hold_ans", rsp_ans, ea);
         chk("hold_flags", {rsp_id, rsp_cout, rsp_v}, {win, ec, ev});
         chk("hold_readies", {req0_ready, req1_ready}, 2'b00);
      end
      req0_valid = v0; req1_valid = v1;
      rsp_ready = 1'b1;
      @(posedge clk);
      #1;
      rsp_ready = 1'b0;
      chk("rsp_cleared", rsp_valid, 1'b0);
   endtask

   task automatic do_reset();
      req0_valid = 1'b0; req1_valid = 1'b0; rsp_ready = 1'b0;
      rst = 1'b1;
      repeat (2) @(posedge clk);
      #1;
      check_reset_outputs("reset");
      rst = 1'b0;
      last_winner = 1'b1;
   endtask

   initial begin
      logic        pat0, pat1;
      logic [31:0] x;
      bit          got;
      rst = 1'b1;
      req0_valid = 1'b0; req0_a = '0; req0_b = '0; req0_sub = 1'b0;
      req1_valid = 1'b0; req1_a = '0; req1_b = '0; req1_sub = 1'b0;
      rsp_ready = 1'b0;
      do_reset();

      // Directed arithmetic cases.
      run_op(1'b1, 1'b0, 32'h00000021, 32'h00000022, 1'b0, 32'h0, 32'h0, 1'b0, 0);
      run_op(1'b0, 1'b1, 32'h0, 32'h0, 1'b0, 32'h7FFFFFFF, 32'h00000001, 1'b0, 0);
      run_op(1'b1, 1'b0, 32'h80000000, 32'h00000001, 1'b1, 32'h0, 32'h0, 1'b0, 0);

      // Both requesters valid from reset: strict alternation 0,1,0,1.
      do_reset();
      for (int n = 0; n < 4; n++) begin
         run_op(1'b1, 1'b1, 32'h336FB7E5, 32'h336FB7E5, 1'b1, 32'h336FB7E5, 32'h336FB7E5, 1'b1, 0);
      end

      // Long consumer stall.
      run_op(1'b1, 1'b0, 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h0, 32'h0, 1'b0, 20);

      // Random traffic.
      for (int n = 0; n < 12; n++) begin
         x = 32'($urandom_range(1, 3));
         pat0 = x[0]; pat1 = x[1];
         run_op(pat0, pat1, $urandom, $urandom, 1'($urandom),
                $urandom, $urandom, 1'($urandom), $urandom_range(0, 3));
      end

      // Reset in the middle of the settle window.
      req0_valid = 1'b1; req0_a = 32'h12345678; req0_b = 32'h11111111; req0_sub = 1'b0;
      req1_valid = 1'b0;
      got = 0;
      for (int k = 0; k < 20; k++) begin
         @(negedge clk);
         if (req0_ready || req1_ready) begin
            got = 1;
            break;
         end
      end
      chk("midrst_grant_seen", got, 1'b1);
      @(posedge clk);
      repeat (3) @(posedge clk);
      #3;
      req0_valid = 1'b1; req1_valid = 1'b1;
      rst = 1'b1;
      #1;
      check_reset_outputs("midrst");
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (2) @(posedge clk);
      #1;
      rst = 1'b0;
      last_winner = 1'b1;
      for (int k = 0; k < S + 4; k++) begin
         @(negedge clk);
         chk("no_rsp_after_rst", rsp_valid, 1'b0);
      end
      @(posedge clk);
      #1;
      run_op(1'b1, 1'b1, 32'h00000005, 32'h00000007, 1'b1, 32'h00000009, 32'h00000001, 1'b0, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
      $finish;
   end

endmodule
